// File: rtl/l2_strm_prefetch_ctrl.sv
// Streaming L2 prefetch controller: issues line-aligned host requests for a
// byte range into an l2_ncl-slot ring and hands filled slots to L1 reads.
module l2_strm_prefetch_ctrl #(
  parameter int unsigned addr_width = 64,
  parameter int unsigned cache_line = 128,
  parameter int unsigned l2_ncl     = 256,
  parameter int unsigned max_outst  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_rst_v,
  output logic                        i_rst_r,
  input  logic [addr_width-1:0]       i_rst_ea_b,
  input  logic [addr_width-1:0]       i_rst_ea_e,
  output logic                        o_rst_v,
  input  logic                        o_rst_r,
  output logic                        o_rst_end,
  input  logic                        i_rd_v,
  output logic                        i_rd_r,
  output logic                        o_addr_v,
  input  logic                        o_addr_r,
  output logic [$clog2(l2_ncl)-1:0]   o_addr_ptr,
  output logic                        o_req_v,
  input  logic                        o_req_r,
  output logic [addr_width-1:0]       o_req_ea,
  input  logic                        i_rsp_v,
  output logic                        i_rsp_r,
  output logic                        o_end
);

  localparam int unsigned cl_w  = $clog2(cache_line);
  localparam int unsigned ncl_w = $clog2(l2_ncl);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic [ncl_w:0]      MAX_OUT   = (ncl_w+1)'(max_outst);
  localparam logic [ncl_w+1:0]    NCL_CNT   = (ncl_w+2)'(l2_ncl);
  localparam logic [addr_width-1:0] LINE_B  = addr_width'(1) << cl_w;
  localparam logic [addr_width-1:0] LINE_MSK = ~(LINE_B - addr_width'(1));

  logic [1:0]            r_state;
  logic [addr_width-1:0] r_req_ea;
  logic [addr_width-1:0] r_ea_e;
  logic [ncl_w:0]        r_nreq;
  logic [ncl_w:0]        r_nvalid;
  logic [ncl_w-1:0]      r_rd_ptr;
  logic [ncl_w-1:0]      r_wr_ptr;

  logic                  w_run;
  logic                  w_done;
  logic                  w_have;
  logic [ncl_w+1:0]      w_sum;
  logic                  w_req_xfer;
  logic                  w_addr_xfer;
  logic                  w_rsp_ok;
  logic                  w_rsp_keep;
  logic                  w_rst_xfer;
  logic [ncl_w:0]        w_nreq_nxt;
  logic [ncl_w:0]        w_nvalid_nxt;

  assign w_run  = (r_state == S_RUN);
  assign w_done = (r_req_ea >= r_ea_e);
  assign w_have = (r_nvalid != '0);
  assign w_sum  = {1'b0, r_nreq} + {1'b0, r_nvalid};

  // Request gating uses only registered counters, keeping o_req_v off any
  // combinational path from the handshake inputs.
  assign o_req_v    = w_run & ~w_done & (r_nreq < MAX_OUT) & (w_sum < NCL_CNT);
  assign o_req_ea   = r_req_ea;
  assign o_addr_v   = i_rd_v & w_run & w_have;
  assign i_rd_r     = o_addr_r & w_run & w_have;
  assign o_addr_ptr = r_rd_ptr;
  assign i_rst_r    = (r_state == S_IDLE) | (r_state == S_RUN);
  assign o_rst_v    = (r_state == S_ACK);
  assign o_rst_end  = w_done;
  assign i_rsp_r    = 1'b1;
  assign o_end      = w_run & w_done & (r_nreq == '0) & ~w_have;

  assign w_req_xfer  = o_req_v & o_req_r;
  assign w_addr_xfer = o_addr_v & o_addr_r;
  assign w_rsp_ok    = i_rsp_v & (r_nreq != '0);
  assign w_rsp_keep  = w_rsp_ok & w_run;
  assign w_rst_xfer  = i_rst_v & i_rst_r;

  assign w_nreq_nxt   = r_nreq + (ncl_w+1)'(w_req_xfer) - (ncl_w+1)'(w_rsp_ok);
  assign w_nvalid_nxt = r_nvalid + (ncl_w+1)'(w_rsp_keep) - (ncl_w+1)'(w_addr_xfer);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_req_ea <= '0;
      r_ea_e   <= '0;
      r_nreq   <= '0;
      r_nvalid <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_nreq   <= w_nreq_nxt;
      r_nvalid <= w_nvalid_nxt;
      if (w_addr_xfer) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rsp_keep)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_req_xfer)  r_req_ea <= r_req_ea + LINE_B;
      case (r_state)
        S_IDLE, S_RUN: begin
          if (w_rst_xfer) begin
            r_req_ea <= i_rst_ea_b & LINE_MSK;
            r_ea_e   <= i_rst_ea_e;
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Leave as soon as the last outstanding response lands this cycle.
          if (w_nreq_nxt == '0) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_nvalid <= '0;
            r_state  <= S_ACK;
          end
        end
        S_ACK: begin
          if (o_rst_r) r_state <= S_RUN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_strm_prefetch_ctrl.sv
// Bench for l2_strm_prefetch_ctrl: queue-based stream model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_l2_strm_prefetch_ctrl;
  localparam int AW  = 64;
  localparam int CL  = 128;
  localparam int NCL = 4;
  localparam int MO  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_rst_v, i_rst_r;
  logic [AW-1:0] i_rst_ea_b, i_rst_ea_e;
  logic          o_rst_v, o_rst_r, o_rst_end;
  logic          i_rd_v, i_rd_r;
  logic          o_addr_v, o_addr_r;
  logic [1:0]    o_addr_ptr;
  logic          o_req_v, o_req_r;
  logic [AW-1:0] o_req_ea;
  logic          i_rsp_v, i_rsp_r;
  logic          o_end;

  always #5 clk = ~clk;

  l2_strm_prefetch_ctrl #(
    .addr_width(AW), .cache_line(CL), .l2_ncl(NCL), .max_outst(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_rst_v(i_rst_v), .i_rst_r(i_rst_r),
    .i_rst_ea_b(i_rst_ea_b), .i_rst_ea_e(i_rst_ea_e),
    .o_rst_v(o_rst_v), .o_rst_r(o_rst_r), .o_rst_end(o_rst_end),
    .i_rd_v(i_rd_v), .i_rd_r(i_rd_r),
    .o_addr_v(o_addr_v), .o_addr_r(o_addr_r), .o_addr_ptr(o_addr_ptr),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_ea(o_req_ea),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r),
    .o_end(o_end)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: next line address, end, outstanding count, FIFO of filled slots.
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_ACK} mst_t;
  mst_t        ms = M_IDLE;
  logic [63:0] m_next, m_end;
  int          m_out;
  int          m_slots[$];
  int          m_wr;
  bit          m_ok = 1'b0;

  function automatic bit e_req_v();
    return (ms == M_RUN) && (m_next < m_end) && (m_out < MO) &&
           ((m_out + m_slots.size()) < NCL);
  endfunction

  function automatic bit e_have();
    return (ms == M_RUN) && (m_slots.size() > 0);
  endfunction

  always @(posedge clk) begin
    bit rx, ax, sx, tx;
    if (reset) begin
      ms = M_IDLE; m_next = '0; m_end = '0; m_out = 0; m_wr = 0;
      m_slots.delete();
      m_ok = 1'b1;
    end else if (m_ok) begin
      rx = e_req_v() && o_req_r;
      ax = e_have() && i_rd_v && o_addr_r;
      sx = i_rsp_v && (m_out > 0);
      tx = i_rst_v && (ms == M_IDLE || ms == M_RUN);
      if (ax) void'(m_slots.pop_front());
      if (rx) begin m_next += 64'(CL); m_out++; end
      if (sx) begin
        m_out--;
        if (ms == M_RUN) begin m_slots.push_back(m_wr); m_wr = (m_wr + 1) % NCL; end
      end
      case (ms)
        M_IDLE, M_RUN: if (tx) begin
          m_next = i_rst_ea_b & ~64'(CL - 1);
          m_end  = i_rst_ea_e;
          ms     = M_DRAIN;
        end
        M_DRAIN: if (m_out == 0) begin m_slots.delete(); m_wr = 0; ms = M_ACK; end
        M_ACK:   if (o_rst_r) ms = M_RUN;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("req_v", o_req_v, e_req_v());
      if (e_req_v()) chk("req_ea", o_req_ea, m_next);
      chk("addr_v", o_addr_v, e_have() && i_rd_v);
      chk("rd_r", i_rd_r, e_have() && o_addr_r);
      if (e_have()) chk("addr_ptr", o_addr_ptr, m_slots[0]);
      chk("rst_r", i_rst_r, (ms == M_IDLE) || (ms == M_RUN));
      chk("rst_v", o_rst_v, ms == M_ACK);
      if (ms == M_ACK) chk("rst_end", o_rst_end, m_next >= m_end);
      chk("end", o_end, (ms == M_RUN) && (m_next >= m_end) && (m_out == 0) && (m_slots.size() == 0));
      chk("rsp_r", i_rsp_r, 1);
    end
  end

  // Stimulus side: host responder bookkeeping and transfer logs.
  logic [63:0] reqlog[$];
  int          ptrlog[$];
  int          pend = 0;
  int          pend_max = 0;
  bit          rsp_en = 1'b0;
  bit          rsp_force = 1'b0;

  task automatic pre();
    i_rsp_v = rsp_force || (rsp_en && pend > 0);
    @(negedge clk);
    if (o_req_v && o_req_r) begin pend++; reqlog.push_back(o_req_ea); end
    if (o_addr_v && o_addr_r) ptrlog.push_back(int'(o_addr_ptr));
    if (i_rsp_v && pend > 0) pend--;
    if (pend > pend_max) pend_max = pend;
  endtask

  task automatic post();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    pre(); post();
  endtask

  task automatic start_stream(input logic [63:0] b, input logic [63:0] e,
                              input logic exp_end, output int lat);
    i_rst_ea_b = b; i_rst_ea_e = e; i_rst_v = 1'b1;
    lat = 0;
    pre();
    while (!i_rst_r && lat < 50) begin post(); pre(); lat++; end
    post();
    i_rst_v = 1'b0; rsp_en = 1'b1;
    pre();
    chk("drain_rst_r", i_rst_r, 0);
    lat = 0;
    while (!o_rst_v && lat < 50) begin post(); pre(); lat++; end
    chk("rst_v_seen", o_rst_v, 1);
    if (o_rst_v) chk("rst_end_lit", o_rst_end, exp_end);
    o_rst_r = 1'b1;
    post();
    o_rst_r = 1'b0;
    reqlog.delete(); ptrlog.delete();
  endtask

  task automatic run_to_end(input string nm);
    int n = 0;
    pre();
    while (!o_end && n < 80) begin post(); pre(); n++; end
    chk(nm, o_end, 1);
    post();
  endtask

  initial begin
    int lat;
    bit hit;
    logic [63:0] exp_req[4];
    int exp_ptr[6];
    exp_req = '{64'h1000, 64'h1080, 64'h1100, 64'h1180};
    exp_ptr = '{0, 1, 2, 3, 0, 1};

    reset = 1'b1; i_rst_v = 1'b0; i_rst_ea_b = '0; i_rst_ea_e = '0;
    o_rst_r = 1'b0; i_rd_v = 1'b0; o_addr_r = 1'b0; o_req_r = 1'b0; i_rsp_v = 1'b0;
    rsp_force = 1'b1;
    tick(); tick();
    rsp_force = 1'b0;
    pre();
    chk("rst_o_rst_v", o_rst_v, 0); chk("rst_o_req_v", o_req_v, 0);
    chk("rst_o_addr_v", o_addr_v, 0); chk("rst_o_end", o_end, 0);
    chk("rst_i_rst_r", i_rst_r, 1); chk("rst_i_rsp_r", i_rsp_r, 1);
    reset = 1'b0;
    post();
    pend = 0;

    // Basic stream
    start_stream(64'h1010, 64'h1200, 1'b0, lat);
    o_req_r = 1'b1; i_rd_v = 1'b1; o_addr_r = 1'b1;
    run_to_end("basic_end");
    chk("basic_nreq", reqlog.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_req%0d", i), reqlog[i], exp_req[i]);
    chk("basic_nrd", ptrlog.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_ptr%0d", i), ptrlog[i], exp_ptr[i]);
    chk("basic_max_out", pend_max <= MO, 1);

    // Window full
    o_req_r = 1'b0; i_rd_v = 1'b0;
    start_stream(64'h4000, 64'h8000, 1'b0, lat);
    o_req_r = 1'b1;
    repeat (12) tick();
    chk("full_nreq", reqlog.size(), 4);
    pre(); chk("full_req_v", o_req_v, 0); post();
    i_rd_v = 1'b1;
    pre(); chk("full_addr_v", o_addr_v, 1); post();
    i_rd_v = 1'b0;
    repeat (6) tick();
    chk("full_one_more", reqlog.size(), 5);
    pre(); chk("full_req_v2", o_req_v, 0); post();

    // Empty stream, then a stray response that must be ignored
    o_req_r = 1'b0;
    start_stream(64'h2000, 64'h2000, 1'b1, lat);
    o_req_r = 1'b1; i_rd_v = 1'b1; o_addr_r = 1'b1;
    pre();
    chk("empty_req_v", o_req_v, 0); chk("empty_end", o_end, 1); chk("empty_rd_r", i_rd_r, 0);
    post();
    rsp_force = 1'b1; tick(); rsp_force = 1'b0;
    pre(); chk("stray_rsp_end", o_end, 1); chk("stray_rsp_rd_r", i_rd_r, 0); post();

    // Abort with two outstanding requests
    o_req_r = 1'b0; i_rd_v = 1'b0;
    start_stream(64'h5000, 64'h6000, 1'b0, lat);
    rsp_en = 1'b0; o_req_r = 1'b1;
    for (int n = 0; n < 20 && pend < 2; n++) tick();
    chk("abort_two_out", pend, 2);
    o_req_r = 1'b0;
    start_stream(64'h7040, 64'h7100, 1'b0, lat);
    chk("abort_rst_v_lat", lat, 2);
    chk("abort_absorbed", pend, 0);
    o_req_r = 1'b1; i_rd_v = 1'b1; o_addr_r = 1'b1;
    pre();
    chk("abort_nvalid0", o_addr_v, 0); chk("abort_req_v", o_req_v, 1);
    chk("abort_new_ea", o_req_ea, 64'h7000);
    post();
    run_to_end("abort_end");

    // Simultaneous request, response and read
    o_req_r = 1'b0; i_rd_v = 1'b0; o_addr_r = 1'b0;
    start_stream(64'h9000, 64'h0000_A000, 1'b0, lat);
    rsp_en = 1'b0; o_req_r = 1'b1; tick(); o_req_r = 1'b0;
    rsp_en = 1'b1; tick(); rsp_en = 1'b0;
    o_req_r = 1'b1; tick(); o_req_r = 1'b0;
    o_req_r = 1'b1; rsp_en = 1'b1; i_rd_v = 1'b1; o_addr_r = 1'b1;
    pre();
    chk("sim_req_v", o_req_v, 1); chk("sim_req_ea", o_req_ea, 64'h9100);
    chk("sim_addr_v", o_addr_v, 1); chk("sim_ptr", o_addr_ptr, 0);
    post();
    o_req_r = 1'b0; rsp_en = 1'b0; o_addr_r = 1'b0;
    pre();
    chk("sim_nvalid1", o_addr_v, 1); chk("sim_ptr_adv", o_addr_ptr, 1);
    chk("sim_ea_adv", o_req_ea, 64'h9180); chk("sim_nreq1", o_req_v, 1);
    post();

    // Pointer wrap over six lines
    i_rd_v = 1'b0; rsp_en = 1'b1;
    start_stream(64'hB000, 64'hB300, 1'b0, lat);
    o_req_r = 1'b1; i_rd_v = 1'b1; o_addr_r = 1'b1;
    run_to_end("wrap_end");
    chk("wrap_nreq", reqlog.size(), 6);
    chk("wrap_nrd", ptrlog.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("wrap_ptr%0d", i), ptrlog[i], exp_ptr[i]);

    // Synchronous reset coinciding with the 5th read
    o_req_r = 1'b0; i_rd_v = 1'b0;
    start_stream(64'hC000, 64'hC300, 1'b0, lat);
    o_req_r = 1'b1; i_rd_v = 1'b1; o_addr_r = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      pre();
      if (ptrlog.size() == 5) begin reset = 1'b1; hit = 1'b1; end
      post();
    end
    reset = 1'b0; pend = 0;
    chk("wrap_rst_hit", hit, 1);
    chk("wrap_rst_ptr4", ptrlog[4], 0);
    pre();
    chk("wrst_o_rst_v", o_rst_v, 0); chk("wrst_o_req_v", o_req_v, 0);
    chk("wrst_o_addr_v", o_addr_v, 0); chk("wrst_o_end", o_end, 0);
    chk("wrst_i_rst_r", i_rst_r, 1); chk("wrst_i_rsp_r", i_rsp_r, 1);
    post();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
